calib_pipeline: RTL and testbench
=================================

Name: calib_pipeline

Overview:
- Parametrised N-channel gain/offset calibration stage between the waveform generators and the DAC formatter.
- Each channel applies a fixed-point gain with round-half-up, then either a signed offset or a toward-zero trim, then saturates to the data width.
- Coefficients are double-buffered: shadow registers take writes, and an explicit commit moves them to active registers. Samples flow through a fixed 3-cycle valid-qualified pipeline.

Parameters:
- NUM_CH, 2, number of channels processed in lockstep.
- DATA_W, 16, signed sample width, input and output.
- GAIN_W, 16, unsigned gain coefficient width.
- GAIN_FRAC, 8, fractional bits of gain (1.0 = 1<<GAIN_FRAC).
- OFF_W, 8, signed offset/trim coefficient width.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  input samples valid this cycle.
- in_data  in  NUM_CH*DATA_W  signed samples, channel k at bits [k*DATA_W +: DATA_W].
- cfg_we  in  1  write shadow coefficients of channel cfg_ch.
- cfg_ch  in  $clog2(NUM_CH) (min 1)  channel index for the write.
- cfg_gain  in  GAIN_W  unsigned gain value.
- cfg_offset  in  OFF_W  signed offset value, or trim magnitude.
- cfg_trim  in  1  offset mode: 0 = signed add, 1 = toward-zero trim.
- cfg_commit  in  1  copy all shadow coefficients to the active registers.
- out_valid  out  1  output samples valid.
- out_data  out  NUM_CH*DATA_W  calibrated signed samples.
- sat_flag  out  NUM_CH  per-channel saturation for the current out_valid sample.
- sat_sticky  out  NUM_CH  latched saturation history.
- sat_clr  in  1  clear sat_sticky.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - out_valid, out_data, sat_flag and sat_sticky go to 0; the pipeline valid bits are cleared.
  - Shadow and active gains go to 1<<GAIN_FRAC; offsets and trim go to 0.
  - Reset mid-stream drops all in-flight samples, with no partial outputs.
- Pipeline:
  - Exactly 3 cycles, in_valid to out_valid. Full throughput, one sample set per cycle, no backpressure.
  - S1: register in_data together with a snapshot of the active coefficients. Product = sample * gain, sign-correct with the gain as unsigned (zero-extended), width DATA_W+GAIN_W+1.
  - S2: r = (product + 2^(GAIN_FRAC-1)) >>> GAIN_FRAC, arithmetic (floor of x+0.5). The intermediate is kept at full width with no truncation.
  - S3 add mode: y = r + sign-extended offset.
  - S3 trim mode: m = |offset| (offset -128 gives m = 128).
    - r>0: y = max(r-m, 0).
    - r<0: y = min(r+m, 0).
    - r=0: y = 0.
    - Trim never crosses zero.
  - S3 saturation: clamp y to [-2^(DATA_W-1), 2^(DATA_W-1)-1]. sat_flag[k]=1 if clamped, registered with out_data.
- out_data holds its last value when out_valid=0; sat_flag is 0 when out_valid=0.
- sat_sticky[k] sets on any sat_flag[k]. sat_clr clears it; when set and clear coincide, set wins.
- Config:
  - cfg_we writes the shadow registers of channel cfg_ch only. A cfg_ch of NUM_CH or above is ignored.
  - cfg_commit updates the active set at the clk edge. A sample entering S1 in that same cycle uses the old coefficients; the next cycle uses the new ones.
  - When cfg_we and cfg_commit coincide, the commit copies the pre-write shadow value. The write lands in shadow only.
  - In-flight samples keep their S1 snapshot, so a commit never corrupts a sample mid-pipe.
- Channels are fully independent except for the shared valid and commit.

Decomposition:
- calib_pkg holds:
  - the coefficient struct {gain, offset, trim};
  - the GAIN_ONE constant;
  - the round and saturate functions, parametrised by width through localparams in the module.
- One sub-module, calib_lane: a single-channel S1–S3 datapath with its sat_flag, instantiated NUM_CH times via generate.
- calib_pipeline owns the valid pipeline, the shadow and active registers, and sat_sticky.

Test Plan:
- Reset defaults: after reset, in_data ch0=1000, ch1=-1000 -> out 3 cycles later 1000/-1000, sat_flag 0.
- Gain with add offset:
  - Program ch0 gain 250, offset -3, trim 0, then commit. Drive 1000 -> 974 (250000+128>>>8 = 977, minus 3).
  - Drive -1000 -> -980 (-977 minus 3).
- Trim mode: ch1 gain 250, offset 3, trim 1.
  - 1000 -> 974; -1000 -> -974.
  - At gain 256, input 2 -> 0 and input -1 -> 0 (no zero crossing).
- Saturation: ch0 gain 512 (2.0), offset 0.
  - 20000 -> 32767, sat_flag[0]=1. -20000 -> -32768.
  - sat_sticky[0] stays 1 until sat_clr; a simultaneous saturation and sat_clr leaves it 1.
- Commit timing: stream 1000 back to back on ch0; write gain 512 and pulse commit in cycle t.
  - Samples entering in cycles ≤t output 1000; samples entering after t output 2000.
  - Write alone, without commit, changes nothing.
- Reset mid-stream: with 3 samples in flight, assert rst_n=0 for one cycle -> out_valid stays 0 for the next 3 cycles and gains read back as 1.0.

Source files
------------

// File: rtl/calib_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calib_pkg: coefficient record, unity gain and fixed-point helpers.
// Rev 1.0
// ----------------------------------------------------------------------------
package calib_pkg;

  localparam int COEF_GAIN_W   = 16;
  localparam int COEF_OFF_W    = 8;
  localparam int DEF_GAIN_FRAC = 8;
  localparam int WIDE_W        = 64;

  typedef struct packed {
    logic [COEF_GAIN_W-1:0] gain;
    logic [COEF_OFF_W-1:0]  offset;
    logic                   trim;
  } coef_t;

  function automatic logic [COEF_GAIN_W-1:0] gain_one(input int frac);
    return COEF_GAIN_W'(1) << frac;
  endfunction

  localparam logic [COEF_GAIN_W-1:0] GAIN_ONE = gain_one(DEF_GAIN_FRAC);

  // floor(x / 2^frac + 0.5); frac must be at least 1
  function automatic logic signed [WIDE_W-1:0] round_half_up(
    input logic signed [WIDE_W-1:0] x,
    input int                       frac
  );
    logic signed [WIDE_W-1:0] half;
    half = $signed(WIDE_W'(1)) <<< (frac - 1);
    return (x + half) >>> frac;
  endfunction

  function automatic logic signed [WIDE_W-1:0] saturate(
    input  logic signed [WIDE_W-1:0] y,
    input  int                       w,
    output logic                     clamped
  );
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    logic signed [WIDE_W-1:0] res;
    hi = ($signed(WIDE_W'(1)) <<< (w - 1)) - 1;
    lo = -($signed(WIDE_W'(1)) <<< (w - 1));
    clamped = 1'b1;
    if (y > hi) begin
      res = hi;
    end else if (y < lo) begin
      res = lo;
    end else begin
      res     = y;
      clamped = 1'b0;
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/calib_lane.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calib_lane: one channel of the gain / round / offset-or-trim / saturate path.
// Rev 1.0
// ----------------------------------------------------------------------------
module calib_lane
  import calib_pkg::*;
#(
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = COEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int OFF_W     = COEF_OFF_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s0_valid_i,
  input  logic              s1_valid_i,
  input  logic              s2_valid_i,
  input  logic [DATA_W-1:0] data_i,
  input  coef_t             coef_i,
  output logic [DATA_W-1:0] data_o,
  output logic              sat_o
);

  localparam int PROD_W = DATA_W + GAIN_W + 1;

  logic signed [PROD_W-1:0] prod_d, prod_q;
  logic signed [PROD_W-1:0] rnd_d, rnd_q;
  logic [OFF_W-1:0]         off1_q, off2_q;
  logic                     trim1_q, trim2_q;
  logic [DATA_W-1:0]        out_d, out_q;
  logic                     sat_d, sat_q;

  logic signed [WIDE_W-1:0] r_w, off_w, mag_w, y_w;

  // Gain is unsigned, so it is zero-extended before the signed multiply.
  assign prod_d = PROD_W'($signed(data_i)) * PROD_W'($signed({1'b0, coef_i.gain}));
  assign rnd_d  = PROD_W'(round_half_up(WIDE_W'(prod_q), GAIN_FRAC));

  always_comb begin
    r_w   = WIDE_W'(rnd_q);
    off_w = WIDE_W'($signed(off2_q));
    mag_w = (off_w < 0) ? -off_w : off_w;
    y_w   = r_w + off_w;
    if (trim2_q) begin
      // Trim pulls toward zero and stops there.
      if (r_w > mag_w) begin
        y_w = r_w - mag_w;
      end else if (r_w < -mag_w) begin
        y_w = r_w + mag_w;
      end else begin
        y_w = '0;
      end
    end
    sat_d = 1'b0;
    out_d = DATA_W'(saturate(y_w, DATA_W, sat_d));
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      prod_q  <= '0;
      off1_q  <= '0;
      trim1_q <= 1'b0;
      rnd_q   <= '0;
      off2_q  <= '0;
      trim2_q <= 1'b0;
      out_q   <= '0;
      sat_q   <= 1'b0;
    end else begin
      if (s0_valid_i) begin
        prod_q  <= prod_d;
        off1_q  <= coef_i.offset;
        trim1_q <= coef_i.trim;
      end
      if (s1_valid_i) begin
        rnd_q   <= rnd_d;
        off2_q  <= off1_q;
        trim2_q <= trim1_q;
      end
      if (s2_valid_i) begin
        out_q <= out_d;
      end
      sat_q <= s2_valid_i & sat_d;
    end
  end

  assign data_o = out_q;
  assign sat_o  = sat_q;

endmodule
`default_nettype wire

// File: rtl/calib_pipeline.sv
`default_nettype none
// ----------------------------------------------------------------------------
// calib_pipeline: N-channel gain/offset calibration with double-buffered coefs.
// Rev 1.0
// ----------------------------------------------------------------------------
module calib_pipeline
  import calib_pkg::*;
#(
  parameter int NUM_CH    = 2,
  parameter int DATA_W    = 16,
  parameter int GAIN_W    = COEF_GAIN_W,
  parameter int GAIN_FRAC = DEF_GAIN_FRAC,
  parameter int OFF_W     = COEF_OFF_W,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     in_valid_i,
  input  logic [NUM_CH*DATA_W-1:0] in_data_i,
  input  logic                     cfg_we_i,
  input  logic [CH_W-1:0]          cfg_ch_i,
  input  logic [GAIN_W-1:0]        cfg_gain_i,
  input  logic [OFF_W-1:0]         cfg_offset_i,
  input  logic                     cfg_trim_i,
  input  logic                     cfg_commit_i,
  output logic                     out_valid_o,
  output logic [NUM_CH*DATA_W-1:0] out_data_o,
  output logic [NUM_CH-1:0]        sat_flag_o,
  output logic [NUM_CH-1:0]        sat_sticky_o,
  input  logic                     sat_clr_i
);

  localparam coef_t c_coef_rst = '{gain: gain_one(GAIN_FRAC), offset: '0, trim: 1'b0};

  coef_t             shadow_q [NUM_CH];
  coef_t             active_q [NUM_CH];
  coef_t             wr_coef_d;
  logic [2:0]        valid_q;
  logic [NUM_CH-1:0] sticky_d, sticky_q;

  always_comb begin
    wr_coef_d = '{gain: cfg_gain_i, offset: cfg_offset_i, trim: cfg_trim_i};
    // A saturation in the same cycle as a clear keeps the bit set.
    sticky_d  = (sticky_q & ~{NUM_CH{sat_clr_i}}) | sat_flag_o;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_CH; k++) begin
        shadow_q[k] <= c_coef_rst;
        active_q[k] <= c_coef_rst;
      end
      valid_q  <= '0;
      sticky_q <= '0;
    end else begin
      // Commit reads the shadow value from before any same-cycle write.
      if (cfg_commit_i) begin
        active_q <= shadow_q;
      end
      for (int k = 0; k < NUM_CH; k++) begin
        if (cfg_we_i && (int'(cfg_ch_i) == k)) begin
          shadow_q[k] <= wr_coef_d;
        end
      end
      valid_q  <= {valid_q[1:0], in_valid_i};
      sticky_q <= sticky_d;
    end
  end

  generate
    for (genvar k = 0; k < NUM_CH; k++) begin : g_lane
      calib_lane #(
        .DATA_W    (DATA_W),
        .GAIN_W    (GAIN_W),
        .GAIN_FRAC (GAIN_FRAC),
        .OFF_W     (OFF_W)
      ) u_lane (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .s0_valid_i (in_valid_i),
        .s1_valid_i (valid_q[0]),
        .s2_valid_i (valid_q[1]),
        .data_i     (in_data_i[k*DATA_W +: DATA_W]),
        .coef_i     (active_q[k]),
        .data_o     (out_data_o[k*DATA_W +: DATA_W]),
        .sat_o      (sat_flag_o[k])
      );
    end
  endgenerate

  assign out_valid_o  = valid_q[2];
  assign sat_sticky_o = sticky_q;

endmodule
`default_nettype wire

// File: tb/tb_calib_pipeline.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_calib_pipeline: directed stimulus checked against a transaction model.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_calib_pipeline;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        cfg_we;
  logic [0:0]  cfg_ch;
  logic [15:0] cfg_gain;
  logic [7:0]  cfg_offset;
  logic        cfg_trim;
  logic        cfg_commit;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  sat_flag;
  logic [1:0]  sat_sticky;
  logic        sat_clr;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  typedef struct {
    int          due;
    logic [31:0] data;
    logic [1:0]  flag;
  } exp_t;

  exp_t        q[$];
  exp_t        e_new;
  int          act_g[2], act_o[2], shd_g[2], shd_o[2];
  bit          act_t[2], shd_t[2];
  logic        exp_valid;
  logic [31:0] exp_data;
  logic [1:0]  exp_flag;
  logic [1:0]  sticky_m;
  int          my;
  bit          ms;

  calib_pipeline #(
    .NUM_CH    (2),
    .DATA_W    (16),
    .GAIN_W    (16),
    .GAIN_FRAC (8),
    .OFF_W     (8)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_data_i    (in_data),
    .cfg_we_i     (cfg_we),
    .cfg_ch_i     (cfg_ch),
    .cfg_gain_i   (cfg_gain),
    .cfg_offset_i (cfg_offset),
    .cfg_trim_i   (cfg_trim),
    .cfg_commit_i (cfg_commit),
    .out_valid_o  (out_valid),
    .out_data_o   (out_data),
    .sat_flag_o   (sat_flag),
    .sat_sticky_o (sat_sticky),
    .sat_clr_i    (sat_clr)
  );

  always #5 clk = ~clk;

  // Arithmetic meaning of one channel: scale, round half up, offset or trim, clamp.
  function automatic void calc(input int x, input int g, input int o, input bit t,
                               output int y, output bit s);
    longint num, r, m, v;
    num = longint'(x) * longint'(g) + 128;
    r   = num / 256;
    if ((num % 256) != 0 && num < 0) r = r - 1;
    if (!t) begin
      v = r + o;
    end else begin
      m = (o < 0) ? -o : o;
      if (r > 0)      v = (r - m > 0) ? r - m : 0;
      else if (r < 0) v = (r + m < 0) ? r + m : 0;
      else            v = 0;
    end
    s = 1'b1;
    if (v > 32767)       y = 32767;
    else if (v < -32768) y = -32768;
    else begin
      y = int'(v);
      s = 1'b0;
    end
  endfunction

  function automatic logic [31:0] pack(input int a, input int b);
    return {b[15:0], a[15:0]};
  endfunction

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic chk_ch(input string name, input int k, input int val);
    check(name, $signed(out_data[k*16 +: 16]), val);
  endtask

  task automatic send(input int d0, input int d1);
    in_data  = pack(d0, d1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cfg_wr(input int ch, input int g, input int o, input bit t);
    cfg_we     = 1'b1;
    cfg_ch     = 1'(ch);
    cfg_gain   = 16'(g);
    cfg_offset = 8'(o);
    cfg_trim   = t;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic commit();
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_commit = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; cfg_we = 1'b0; cfg_ch = '0;
    cfg_gain = '0; cfg_offset = '0; cfg_trim = 1'b0; cfg_commit = 1'b0; sat_clr = 1'b0;

    fork
      // Model: each accepted sample appears two edges after the capturing edge.
      forever begin
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
          q.delete();
          exp_valid = 1'b0; exp_data = '0; exp_flag = '0; sticky_m = '0;
          for (int k = 0; k < 2; k++) begin
            shd_g[k] = 256; shd_o[k] = 0; shd_t[k] = 1'b0;
            act_g[k] = 256; act_o[k] = 0; act_t[k] = 1'b0;
          end
        end else begin
          sticky_m = (sticky_m & ~{2{sat_clr}}) | exp_flag;
          if (in_valid) begin
            e_new.due = cyc + 2;
            for (int k = 0; k < 2; k++) begin
              calc($signed(in_data[k*16 +: 16]), act_g[k], act_o[k], act_t[k], my, ms);
              e_new.data[k*16 +: 16] = my[15:0];
              e_new.flag[k] = ms;
            end
            q.push_back(e_new);
          end
          if (cfg_commit) begin
            for (int k = 0; k < 2; k++) begin
              act_g[k] = shd_g[k]; act_o[k] = shd_o[k]; act_t[k] = shd_t[k];
            end
          end
          if (cfg_we) begin
            shd_g[cfg_ch] = int'(cfg_gain);
            shd_o[cfg_ch] = int'($signed(cfg_offset));
            shd_t[cfg_ch] = cfg_trim;
          end
          if (q.size() > 0 && q[0].due == cyc) begin
            exp_valid = 1'b1; exp_data = q[0].data; exp_flag = q[0].flag;
            void'(q.pop_front());
          end else begin
            exp_valid = 1'b0; exp_flag = '0;
          end
        end
      end
      // Compare every cycle once the bench has reset the design.
      forever begin
        @(negedge clk);
        if (chk_en) begin
          check("out_valid", out_valid, exp_valid);
          for (int k = 0; k < 2; k++) begin
            check($sformatf("out_data ch%0d cyc%0d", k, cyc),
                  $signed(out_data[k*16 +: 16]), $signed(exp_data[k*16 +: 16]));
          end
          check("sat_flag", sat_flag, exp_flag);
          check("sat_sticky", sat_sticky, sticky_m);
        end
      end
    join_none

    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    chk_en = 1'b1;
    check("rst out_valid", out_valid, 0);
    check("rst out_data", out_data, 0);
    check("rst sticky", sat_sticky, 0);

    send(1000, -1000);
    check("dflt valid", out_valid, 1);
    chk_ch("dflt ch0", 0, 1000);
    chk_ch("dflt ch1", 1, -1000);
    check("dflt sat", sat_flag, 0);

    cfg_wr(0, 250, -3, 1'b0); commit();
    send(1000, 0);  chk_ch("add ch0 pos", 0, 974);
    send(-1000, 0); chk_ch("add ch0 neg", 0, -980);

    cfg_wr(1, 250, 3, 1'b1); commit();
    send(0, 1000);  chk_ch("trim ch1 pos", 1, 974);
    send(0, -1000); chk_ch("trim ch1 neg", 1, -974);
    cfg_wr(1, 256, 3, 1'b1); commit();
    send(0, 2);     chk_ch("trim small pos", 1, 0);
    send(0, -1);    chk_ch("trim small neg", 1, 0);

    cfg_wr(0, 512, 0, 1'b0); commit();
    send(20000, 0);
    chk_ch("sat hi", 0, 32767);
    check("sat flag hi", sat_flag[0], 1);
    sat_clr = 1'b1; @(negedge clk); sat_clr = 1'b0;
    check("sticky set with clr", sat_sticky[0], 1);
    repeat (2) @(negedge clk);
    check("sticky hold", sat_sticky[0], 1);
    sat_clr = 1'b1; @(negedge clk); sat_clr = 1'b0;
    check("sticky clr", sat_sticky[0], 0);
    send(-20000, 0);
    chk_ch("sat lo", 0, -32768);
    check("sat flag lo", sat_flag[0], 1);
    @(negedge clk);
    check("sat flag idle", sat_flag, 0);

    cfg_wr(0, 256, 0, 1'b0); commit();
    for (int i = 0; i < 11; i++) begin
      if (i >= 3) chk_ch($sformatf("commit edge s%0d", i - 3), 0, ((i - 3) <= 4) ? 1000 : 2000);
      in_valid   = (i < 8);
      in_data    = pack(1000, 0);
      cfg_we     = (i == 2);
      cfg_ch     = 1'b0;
      cfg_gain   = 16'd512;
      cfg_offset = 8'd0;
      cfg_trim   = 1'b0;
      cfg_commit = (i == 4);
      @(negedge clk);
    end
    in_valid = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0;

    cfg_we = 1'b1; cfg_ch = 1'b0; cfg_gain = 16'd768; cfg_offset = 8'd0; cfg_trim = 1'b0;
    cfg_commit = 1'b1;
    @(negedge clk);
    cfg_we = 1'b0; cfg_commit = 1'b0;
    send(1000, 0); chk_ch("we+commit keeps old", 0, 2000);
    commit();
    send(1000, 0); chk_ch("late commit", 0, 3000);

    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = pack(500 + i, -500);
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("post-rst valid %0d", i), out_valid, 0);
      @(negedge clk);
    end
    send(1000, -1000);
    chk_ch("post-rst ch0", 0, 1000);
    chk_ch("post-rst ch1", 1, -1000);
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
